// File: rtl/mem_copy_master.sv
// mem_copy_master
//   Word-copy DMA initiator on the picorv32 native memory bus. A job reads
//   len_words 32-bit words starting at src_addr and writes each one to
//   dst_addr. Every word is one read followed by one write. The bus outputs
//   are registered. The master lowers mem_valid for at least one cycle after
//   every completed transfer. With a zero-wait responder each transfer takes
//   2 cycles, so each word takes 4 cycles.
//
// Parameters
//   LEN_W          width of len_words / words_done
//   TIMEOUT_CYCLES max cycles a request may wait for mem_ready. This is used
//                  only when MEM_COPY_TIMEOUT_EN is defined.
//
// Build option
//   MEM_COPY_TIMEOUT_EN : adds a per-transfer wait counter. When it expires,
//                  the transfer is abandoned, error is set and the job ends.
//                  When undefined, the master waits forever and error is 0.
//
// Ports
//   clk, resetn    clock (posedge), asynchronous active-low reset
//   start          1-cycle job request, sampled only in IDLE
//   src_addr       source byte address (bits [1:0] ignored)
//   dst_addr       destination byte address (bits [1:0] ignored)
//   len_words      word count, 0 = empty job
//   abort          stop after the current bus transfer completes
//   busy           high from job acceptance until the return to IDLE
//   irq_done       1-cycle pulse at job end (normal, abort or timeout)
//   error          sticky timeout flag, cleared by the next accepted start
//   words_done     words fully written in the current/last job
//   mem_*          picorv32 native memory bus (master side)
//   dbg_state      current FSM state (0 IDLE, 1 RD, 2 WR, 3 FIN)
//
// Bus handshake: a transfer completes in a cycle where mem_valid and mem_ready
// are both high. While mem_valid is high and mem_ready is low, the master holds
// mem_valid, mem_addr, mem_wdata and mem_wstrb stable. The responder may hold
// mem_ready low for any number of cycles. mem_rdata is taken only in the
// completing cycle.

module mem_copy_master #(
   parameter int unsigned LEN_W          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len_words,
   input  logic             abort,
   output logic             busy,
   output logic             irq_done,
   output logic             error,
   output logic [LEN_W-1:0] words_done,
   output logic             mem_valid,
   output logic             mem_instr,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic             mem_ready,
   input  logic [31:0]      mem_rdata,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       wstrb_q, wstrb_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] words_q, words_d;
   logic             busy_q, busy_d;
   logic             irq_q, irq_d;
   logic             valid_q, valid_d;
   logic             abort_q, abort_d;

   logic             abort_now;
   logic             last_word;
   logic             timeout;

   // An abort may arrive in the completing cycle itself, so the live input
   // counts as well as the latched copy.
   assign abort_now = abort_q | abort;
   // words_done < len holds in WR, so this sum cannot wrap.
   assign last_word = ((words_q + LEN_W'(1)) == len_q);

`ifdef MEM_COPY_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // cnt_q counts the waiting cycles already spent by the open request.
   // Timing out here gives exactly TIMEOUT_CYCLES cycles of mem_valid.
   assign timeout = valid_q && !mem_ready && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = '0;
      err_d = err_q;
      // mem_valid is low between requests, so the counter restarts for each new one.
      if (valid_q && !mem_ready) cnt_d = cnt_q + CNT_W'(1);
      if (state_q == ST_IDLE && start) err_d = 1'b0;
      if (timeout) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign error = err_q;
`else
   assign timeout = 1'b0;
   assign error   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      len_d   = len_q;
      words_d = words_q;
      busy_d  = busy_q;
      irq_d   = 1'b0;
      valid_d = valid_q;
      abort_d = abort_q;

      if (state_q != ST_IDLE && abort) abort_d = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            // An abort in the same cycle as start is ignored (see the latch above).
            if (start) begin
               src_d   = {src_addr[31:2], 2'b00};
               dst_d   = {dst_addr[31:2], 2'b00};
               len_d   = len_words;
               words_d = '0;
               busy_d  = 1'b1;
               abort_d = 1'b0;
               state_d = (len_words == '0) ? ST_FIN : ST_RD;
            end
         end
         ST_RD: begin
            if (!valid_q) begin
               valid_d = 1'b1;
               addr_d  = src_q;
               wstrb_d = 4'b0000;
            end else if (mem_ready) begin
               valid_d = 1'b0;
               src_d   = src_q + 32'd4;
               if (abort_now) begin
                  // The read still completes, but its data is dropped.
                  state_d = ST_FIN;
               end else begin
                  wdata_d = mem_rdata;
                  state_d = ST_WR;
               end
            end else if (timeout) begin
               valid_d = 1'b0;
               state_d = ST_FIN;
            end
         end
         ST_WR: begin
            if (!valid_q) begin
               valid_d = 1'b1;
               addr_d  = dst_q;
               wstrb_d = 4'b1111;
            end else if (mem_ready) begin
               valid_d = 1'b0;
               dst_d   = dst_q + 32'd4;
               words_d = words_q + LEN_W'(1);
               state_d = (last_word || abort_now) ? ST_FIN : ST_RD;
            end else if (timeout) begin
               valid_d = 1'b0;
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            irq_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         len_q   <= '0;
         words_q <= '0;
         busy_q  <= 1'b0;
         irq_q   <= 1'b0;
         valid_q <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         len_q   <= len_d;
         words_q <= words_d;
         busy_q  <= busy_d;
         irq_q   <= irq_d;
         valid_q <= valid_d;
         abort_q <= abort_d;
      end
   end

   assign busy       = busy_q;
   assign irq_done   = irq_q;
   assign words_done = words_q;
   assign mem_valid  = valid_q;
   assign mem_instr  = 1'b0;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_wstrb  = wstrb_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// tb_mem_copy_master
//   Directed bench for mem_copy_master. A behavioural memory responder with
//   optional random stalls serves the bus. Expected writes (address and data)
//   sit in queues and are checked as each write completes. Each job's
//   latency, word count and irq behaviour are checked against hand-computed
//   values.

module tb_mem_copy_master;

   localparam int LEN_W = 16;

   // clock / reset
   logic clk;
   logic resetn;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DUT signals
   logic             start;
   logic [31:0]      src_addr;
   logic [31:0]      dst_addr;
   logic [LEN_W-1:0] len_words;
   logic             abort;
   logic             busy;
   logic             irq_done;
   logic             error;
   logic [LEN_W-1:0] words_done;
   logic             mem_valid;
   logic             mem_instr;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic [3:0]       mem_wstrb;
   logic             mem_ready;
   logic [31:0]      mem_rdata;
   logic [1:0]       dbg_state;

   mem_copy_master #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len_words  (len_words),
      .abort      (abort),
      .busy       (busy),
      .irq_done   (irq_done),
      .error      (error),
      .words_done (words_done),
      .mem_valid  (mem_valid),
      .mem_instr  (mem_instr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .dbg_state  (dbg_state)
   );

   // scoreboard state
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_wa_q[$];
   logic [31:0] rd_addr_q[$];
   logic [31:0] mem_model [logic [31:0]];
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          valid_cycles = 0;
   int          irq_cnt = 0;
   int          stall_max = 0;
   bit          ready_stuck = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // memory responder (drives at negedge, DUT samples at posedge)
   bit          req_active = 0;
   int          stall_left = 0;
   logic [31:0] h_addr, h_wdata;
   logic [3:0]  h_wstrb;

   always @(negedge clk) begin
      if (!resetn) begin
         req_active = 0;
         mem_ready  = 1'b0;
      end else if (mem_ready) begin
         // the transfer completed at the last posedge; mem_valid must now be low
         check_val("valid_gap", 32'(mem_valid), 32'd0);
         mem_ready = 1'b0;
      end else if (mem_valid) begin
         valid_cycles++;
         if (!req_active) begin
            req_active = 1;
            h_addr     = mem_addr;
            h_wdata    = mem_wdata;
            h_wstrb    = mem_wstrb;
            stall_left = (stall_max == 0) ? 0 : int'($urandom_range(stall_max, 0));
         end else begin
            check_val("stall_addr", mem_addr, h_addr);
            check_val("stall_wdata", mem_wdata, h_wdata);
            check_val("stall_wstrb", 32'(mem_wstrb), 32'(h_wstrb));
         end
         if (stall_left == 0 && !ready_stuck) begin
            mem_ready  = 1'b1;
            req_active = 0;
            if (mem_wstrb == 4'hF) begin
               wr_cnt++;
               if (exp_q.size() == 0) begin
                  check_val("unexpected_write", mem_addr, 32'hFFFF_FFFF);
               end else begin
                  check_val("wr_addr", mem_addr, exp_wa_q.pop_front());
                  check_val("wr_data", mem_wdata, exp_q.pop_front());
               end
               mem_model[mem_addr] = mem_wdata;
            end else begin
               check_val("rd_wstrb", 32'(mem_wstrb), 32'd0);
               rd_cnt++;
               rd_addr_q.push_back(mem_addr);
               mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
            end
         end else begin
            if (stall_left > 0) stall_left--;
            mem_rdata = $urandom;
         end
      end else begin
         req_active = 0;
      end
   end

   always @(negedge clk) begin
      if (resetn && irq_done) irq_cnt++;
   end

   // driver tasks
   task automatic fill(input logic [31:0] base, input int n, input logic [31:0] seed);
      for (int i = 0; i < n; i++) mem_model[base + 32'(4 * i)] = seed + 32'(i) * 32'h0101_0101;
   endtask

   task automatic queue_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
      logic [31:0] s, d;
      s = {src[31:2], 2'b00};
      d = {dst[31:2], 2'b00};
      for (int i = 0; i < n; i++) begin
         exp_wa_q.push_back(d + 32'(4 * i));
         exp_q.push_back(mem_model[s + 32'(4 * i)]);
      end
   endtask

   task automatic clear_sb();
      exp_q.delete();
      exp_wa_q.delete();
      rd_addr_q.delete();
      wr_cnt       = 0;
      rd_cnt       = 0;
      valid_cycles = 0;
   endtask

   task automatic start_job(input logic [31:0] src, input logic [31:0] dst,
                            input logic [LEN_W-1:0] len, input logic with_abort);
      @(negedge clk);
      src_addr  = src;
      dst_addr  = dst;
      len_words = len;
      abort     = with_abort;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   // cyc counts cycles after the start cycle (1 = first cycle after acceptance).
   // amode 1: abort on the completing cycle of write #3; amode 2: read #2.
   task automatic wait_irq(input int budget, input int amode, output int cyc);
      bit fired;
      fired = 0;
      #1;
      cyc = 1;
      check_val("busy_after_start", 32'(busy), 32'd1);
      while (!irq_done && cyc < budget) begin
         if (!fired && amode == 1 && mem_valid && mem_wstrb == 4'hF && wr_cnt == 3) begin
            abort = 1'b1; fired = 1;
         end else if (!fired && amode == 2 && mem_valid && mem_wstrb == 4'h0 && rd_cnt == 2) begin
            abort = 1'b1; fired = 1;
         end else begin
            abort = 1'b0;
         end
         @(negedge clk);
         #1;
         cyc++;
      end
      abort = 1'b0;
      if (!irq_done) check_val("irq_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int cyc;
      int irq0;
      start       = 1'b0;
      src_addr    = '0;
      dst_addr    = '0;
      len_words   = '0;
      abort       = 1'b0;
      mem_ready   = 1'b0;
      mem_rdata   = '0;
      resetn      = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_irq", 32'(irq_done), 32'd0);
      check_val("rst_error", 32'(error), 32'd0);
      check_val("rst_words", 32'(words_done), 32'd0);
      check_val("rst_valid", 32'(mem_valid), 32'd0);
      check_val("rst_instr", 32'(mem_instr), 32'd0);
      check_val("rst_addr", mem_addr, 32'd0);
      check_val("rst_wdata", mem_wdata, 32'd0);
      check_val("rst_wstrb", 32'(mem_wstrb), 32'd0);
      check_val("rst_state", 32'(dbg_state), 32'd0);
      resetn = 1'b1;

      // zero-wait copy of 4 words: 4 cycles per word, irq two cycles after the last write
      clear_sb();
      fill(32'h100, 4, 32'hA000_0000);
      queue_copy(32'h100, 32'h200, 4);
      irq0 = irq_cnt;
      start_job(32'h100, 32'h200, 16'd4, 1'b0);
      wait_irq(100, 0, cyc);
      check_val("t1_latency", 32'(cyc), 32'd18);
      check_val("t1_words", 32'(words_done), 32'd4);
      check_val("t1_busy_at_irq", 32'(busy), 32'd0);
      @(negedge clk); #1;
      check_val("t1_irq_one_cycle", 32'(irq_done), 32'd0);
      check_val("t1_busy_after", 32'(busy), 32'd0);
      check_val("t1_pending", 32'(exp_q.size()), 32'd0);
      check_val("t1_irq_count", 32'(irq_cnt - irq0), 32'd1);
      check_val("t1_dst_last", mem_model[32'h20C], 32'hA303_0303);

      // empty job: no bus traffic, irq two cycles after start
      clear_sb();
      start_job(32'h700, 32'h780, 16'd0, 1'b0);
      wait_irq(20, 0, cyc);
      check_val("t2_latency", 32'(cyc), 32'd2);
      check_val("t2_words", 32'(words_done), 32'd0);
      check_val("t2_no_valid", 32'(valid_cycles), 32'd0);

      // random stalls; dst low bits must be ignored
      clear_sb();
      stall_max = 5;
      fill(32'h300, 6, 32'h5A00_0011);
      queue_copy(32'h300, 32'h400, 6);
      start_job(32'h300, 32'h402, 16'd6, 1'b0);
      wait_irq(300, 0, cyc);
      check_val("t3_words", 32'(words_done), 32'd6);
      check_val("t3_pending", 32'(exp_q.size()), 32'd0);
      stall_max = 0;

      // abort on the 3rd write of an 8-word job
      clear_sb();
      fill(32'h800, 8, 32'h1234_0000);
      queue_copy(32'h800, 32'h900, 8);
      start_job(32'h800, 32'h900, 16'd8, 1'b0);
      wait_irq(100, 1, cyc);
      check_val("t4_words", 32'(words_done), 32'd3);
      check_val("t4_writes", 32'(wr_cnt), 32'd3);
      check_val("t4_reads", 32'(rd_cnt), 32'd3);
      check_val("t4_pending", 32'(exp_q.size()), 32'd5);

      // abort on the 2nd read: read completes, its data is not written
      clear_sb();
      fill(32'hA00, 5, 32'h7700_0000);
      queue_copy(32'hA00, 32'hB00, 5);
      start_job(32'hA00, 32'hB00, 16'd5, 1'b0);
      wait_irq(100, 2, cyc);
      check_val("t4b_words", 32'(words_done), 32'd1);
      check_val("t4b_writes", 32'(wr_cnt), 32'd1);
      check_val("t4b_reads", 32'(rd_cnt), 32'd2);

      // start and abort together in IDLE: the job runs to completion
      clear_sb();
      fill(32'hC00, 2, 32'h0BAD_0000);
      queue_copy(32'hC00, 32'hD00, 2);
      start_job(32'hC00, 32'hD00, 16'd2, 1'b1);
      wait_irq(100, 0, cyc);
      check_val("t4c_words", 32'(words_done), 32'd2);
      check_val("t4c_latency", 32'(cyc), 32'd10);

      // source address wraps past the top of the address space
      clear_sb();
      fill(32'hFFFF_FFF8, 3, 32'hCAFE_0000);
      queue_copy(32'hFFFF_FFF8, 32'h600, 3);
      start_job(32'hFFFF_FFF8, 32'h600, 16'd3, 1'b0);
      wait_irq(100, 0, cyc);
      check_val("t5_reads", 32'(rd_addr_q.size()), 32'd3);
      check_val("t5_rd0", (rd_addr_q.size() > 0) ? rd_addr_q[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
      check_val("t5_rd1", (rd_addr_q.size() > 1) ? rd_addr_q[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
      check_val("t5_rd2", (rd_addr_q.size() > 2) ? rd_addr_q[2] : 32'hDEAD_BEEF, 32'h0000_0000);
      check_val("t5_pending", 32'(exp_q.size()), 32'd0);

`ifdef MEM_COPY_TIMEOUT_EN
      // responder never answers: 16 cycles of mem_valid, then error and irq
      clear_sb();
      ready_stuck = 1;
      fill(32'hE00, 2, 32'h0);
      start_job(32'hE00, 32'hF00, 16'd2, 1'b0);
      wait_irq(100, 0, cyc);
      check_val("t6_latency", 32'(cyc), 32'd19);
      check_val("t6_valid_cycles", 32'(valid_cycles), 32'd16);
      check_val("t6_error", 32'(error), 32'd1);
      check_val("t6_words", 32'(words_done), 32'd0);
      ready_stuck = 0;
      clear_sb();
      fill(32'hE00, 1, 32'h4444_0000);
      queue_copy(32'hE00, 32'hF00, 1);
      start_job(32'hE00, 32'hF00, 16'd1, 1'b0);
      #1;
      check_val("t6_error_cleared", 32'(error), 32'd0);
      wait_irq(100, 0, cyc);
      check_val("t6_words_after", 32'(words_done), 32'd1);
`else
      check_val("error_tied_low", 32'(error), 32'd0);
`endif

      // asynchronous reset in the middle of a job
      clear_sb();
      stall_max = 3;
      fill(32'h1000, 8, 32'h9900_0000);
      queue_copy(32'h1000, 32'h1100, 8);
      start_job(32'h1000, 32'h1100, 16'd8, 1'b0);
      repeat (9) @(negedge clk);
      #1;
      check_val("t7_busy_before", 32'(busy), 32'd1);
      irq0   = irq_cnt;
      resetn = 1'b0;
      #1;
      check_val("t7_valid", 32'(mem_valid), 32'd0);
      check_val("t7_busy", 32'(busy), 32'd0);
      check_val("t7_words", 32'(words_done), 32'd0);
      check_val("t7_addr", mem_addr, 32'd0);
      check_val("t7_state", 32'(dbg_state), 32'd0);
      repeat (2) @(negedge clk);
      resetn    = 1'b1;
      stall_max = 0;
      repeat (6) @(negedge clk);
      #1;
      check_val("t7_no_irq", 32'(irq_cnt - irq0), 32'd0);
      check_val("t7_idle", 32'(dbg_state), 32'd0);
      clear_sb();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
